// File: rtl/mano_out_port.sv
// Output-device end of the MANO OUTR/FGO interface: owns OUTR and FGO and drains each
// character onto an async serial line (start, WIDTH data bits LSB-first, stop).
module mano_out_port #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] outr,
  output logic             fgo,
  output logic             tx,
  output logic             busy,
  output logic             ovr
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  outr_q, outr_d;
  logic              fgo_q, fgo_d;
  logic              tx_q, tx_d;
  logic              ovr_q, ovr_d;
  logic              bit_end;
  logic [IdxW-1:0]   idx_inc;

  assign bit_end = (cnt_q == CntMax);
  assign idx_inc = idx_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    outr_d  = outr_q;
    fgo_d   = fgo_q;
    tx_d    = tx_q;
    ovr_d   = ovr_q;

    // A load attempt while the previous character is still draining is an overrun.
    if (ld && !fgo_q) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (ld && fgo_q) begin
          outr_d  = d;
          fgo_d   = 1'b0;
          tx_d    = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = outr_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IdxMax) begin
            // Leave the index at zero so the next frame never starts from a wrapped value.
            idx_d   = '0;
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            idx_d = idx_inc;
            tx_d  = outr_q[idx_inc];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d   = '0;
          fgo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      outr_q  <= '0;
      fgo_q   <= 1'b1;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      outr_q  <= outr_d;
      fgo_q   <= fgo_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

  assign outr = outr_q;
  assign fgo  = fgo_q;
  assign tx   = tx_q;
  assign busy = (state_q != StIdle);
  assign ovr  = ovr_q;

endmodule
